lotr_uart_tx_arb: RTL and testbench

Round-robin arbiter that shares the single UART master TX serializer between NUM_REQ requesters (cores, debug logic).
- Grant is held for a whole packet, from first beat through the beat flagged Last, so bytes from different requesters never interleave on the wire.
- A gap timer reclaims the grant from a requester that stalls mid-packet.
- Sits inside lotr, between the core-side message sources and the UART TX serializer that drives uart_master_rx.

---
 rtl/lotr_uart_arb_pkg.sv | 8 +
 rtl/lotr_rr_pick.sv | 30 +++
 rtl/lotr_uart_tx_arb.sv | 92 +++++++++
 tb/tb_lotr_uart_tx_arb.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lotr_uart_arb_pkg.sv
// lotr_uart_arb_pkg: shared state type and constants for the UART TX arbiter
package lotr_uart_arb_pkg;
    typedef enum logic {IDLE, XFER} t_arb_state;
    localparam logic [7:0] TIMEOUT_CNT_MAX = 8'hFF;
    function automatic int timeout_cnt_w(input int timeout_cyc);
        return $clog2(timeout_cyc + 1);
    endfunction
endpackage

// File: rtl/lotr_rr_pick.sv
// lotr_rr_pick: combinational round-robin picker, searches upward from the entry after LastGrant
module lotr_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] Req,
    input  logic [IDX_W-1:0]   LastGrant,
    output logic [NUM_REQ-1:0] Pick,
    output logic [IDX_W-1:0]   PickIdx,
    output logic               AnyReq
);
    logic [IDX_W-1:0] w_idx;
    logic             w_found;
    assign AnyReq = |Req;
    // first requester after LastGrant, wrapping, wins
    always_comb begin
        Pick    = '0;
        PickIdx = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(LastGrant) + k) % NUM_REQ);
            if (!w_found && Req[w_idx]) begin
                w_found       = 1'b1;
                Pick[w_idx]   = 1'b1;
                PickIdx       = w_idx;
            end
        end
    end
endmodule

// File: rtl/lotr_uart_tx_arb.sv
// lotr_uart_tx_arb: round-robin share of the UART TX serializer, grant held for a whole packet
module lotr_uart_tx_arb
    import lotr_uart_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      QClk,
    input  logic                      RstQnnnH,
    input  logic [NUM_REQ-1:0]        ReqValid,
    input  logic [NUM_REQ*DATA_W-1:0] ReqData,
    input  logic [NUM_REQ-1:0]        ReqLast,
    output logic [NUM_REQ-1:0]        ReqReady,
    output logic                      TxValid,
    output logic [DATA_W-1:0]         TxData,
    input  logic                      TxReady,
    output logic [NUM_REQ-1:0]        GrantOH,
    output logic                      Busy,
    output logic                      TimeoutPulse,
    output logic [7:0]                TimeoutCnt
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TW = timeout_cnt_w(TIMEOUT_CYC);
    localparam logic [TW-1:0] GAP_LIMIT = TW'(TIMEOUT_CYC - 1);

    t_arb_state         r_state, w_next;
    logic [NUM_REQ-1:0] r_grant_oh, w_pick;
    logic [IDX_W-1:0]   r_last_grant, w_pick_idx;
    logic [TW-1:0]      r_gap;
    logic               r_tpulse;
    logic [7:0]         r_tcnt;
    logic               w_any, w_busy, w_gvalid, w_accept, w_timeout, w_release;
    logic [DATA_W-1:0]  w_data [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_data
        assign w_data[i] = ReqData[i*DATA_W +: DATA_W];
    end

    lotr_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .Req       (ReqValid),
        .LastGrant (r_last_grant),
        .Pick      (w_pick),
        .PickIdx   (w_pick_idx),
        .AnyReq    (w_any)
    );

    // r_last_grant doubles as the granted index while in XFER
    assign w_busy       = (r_state == XFER);
    assign w_gvalid     = ReqValid[r_last_grant];
    assign TxValid      = w_busy & w_gvalid & ~RstQnnnH;
    assign TxData       = w_busy ? w_data[r_last_grant] : '0;
    assign ReqReady     = r_grant_oh & {NUM_REQ{TxReady & ~RstQnnnH}};
    assign w_accept     = TxValid & TxReady;
    assign w_timeout    = w_busy & ~w_gvalid & (r_gap == GAP_LIMIT);
    assign w_release    = (w_accept & ReqLast[r_last_grant]) | w_timeout;
    assign GrantOH      = r_grant_oh;
    assign Busy         = w_busy;
    assign TimeoutPulse = r_tpulse;
    assign TimeoutCnt   = r_tcnt;

    // IDLE leaves on any request; XFER ends on the Last beat or a gap timeout
    always_comb begin
        w_next = w_busy ? (w_release ? IDLE : XFER) : (w_any ? XFER : IDLE);
    end

    // grant, gap timer and forced-release bookkeeping
    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            r_state      <= IDLE;
            r_grant_oh   <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_gap        <= '0;
            r_tpulse     <= 1'b0;
            r_tcnt       <= '0;
        end else begin
            r_state  <= w_next;
            r_tpulse <= w_timeout;
            r_tcnt   <= r_tcnt + ((w_timeout && r_tcnt != TIMEOUT_CNT_MAX) ? 8'd1 : 8'd0);
            if (!w_busy) begin
                if (w_any) begin
                    r_grant_oh   <= w_pick;
                    r_last_grant <= w_pick_idx;
                end
                r_gap <= '0;
            end else begin
                if (w_release) r_grant_oh <= '0;
                r_gap <= (w_accept || w_timeout) ? '0 : (w_gvalid ? r_gap : r_gap + 1'b1);
            end
        end
    end
endmodule

// File: tb/tb_lotr_uart_tx_arb.sv
// tb_lotr_uart_tx_arb: directed and randomized checks of the UART TX arbiter against a packet-level model
module tb_lotr_uart_tx_arb;
    localparam int NR = 4;
    localparam int W = 8;
    localparam int TO = 16;

    typedef struct packed {
        logic [7:0]  d;
        logic        last;
        logic [15:0] gap;
    } beat_t;

    logic QClk = 1'b0, rst = 1'b1, tx_rdy = 1'b0;
    logic [NR-1:0] v = '0, l = '0;
    logic [NR*W-1:0] d = '0;
    logic [NR-1:0] ReqReady, GrantOH;
    logic TxValid, Busy, TimeoutPulse;
    logic [W-1:0] TxData;
    logic [7:0] TimeoutCnt;

    lotr_uart_tx_arb #(.NUM_REQ(NR), .DATA_W(W), .TIMEOUT_CYC(TO)) dut (
        .QClk(QClk), .RstQnnnH(rst), .ReqValid(v), .ReqData(d), .ReqLast(l),
        .ReqReady(ReqReady), .TxValid(TxValid), .TxData(TxData), .TxReady(tx_rdy),
        .GrantOH(GrantOH), .Busy(Busy), .TimeoutPulse(TimeoutPulse), .TimeoutCnt(TimeoutCnt)
    );

    always #5 QClk = ~QClk;

    int n_tests = 0, n_fail = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // requester agents: each presents its queued beats, honouring a pre-beat idle gap
    beat_t q[NR][$];
    beat_t tmp;
    logic [NR-1:0] acc = '0;
    int acc_cnt[NR] = '{default: 0};
    always @(negedge QClk) acc = v & ReqReady;
    always @(posedge QClk) begin
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i] && q[i].size() > 0) begin
                void'(q[i].pop_front());
                acc_cnt[i]++;
            end
            if (q[i].size() == 0) v[i] = 1'b0;
            else if (q[i][0].gap != 0) begin
                v[i] = 1'b0;
                tmp = q[i].pop_front();
                tmp.gap = tmp.gap - 16'd1;
                q[i].push_front(tmp);
            end else begin
                v[i] = 1'b1;
                d[i*W +: W] = q[i][0].d;
                l[i] = q[i][0].last;
            end
        end
    end

    // packet-level model: who owns the serializer, how long it has been silent, release count
    int m_gnt = -1, m_last = NR - 1, m_gap = 0, m_cnt = 0;
    bit m_pulse = 0;
    always @(posedge QClk) begin
        if (rst) begin
            m_gnt = -1; m_last = NR - 1; m_gap = 0; m_cnt = 0; m_pulse = 0;
        end else begin
            m_pulse = 0;
            if (m_gnt < 0) begin
                for (int k = 1; k <= NR; k++)
                    if (m_gnt < 0 && v[(m_last + k) % NR]) m_gnt = (m_last + k) % NR;
                if (m_gnt >= 0) begin m_last = m_gnt; m_gap = 0; end
            end else if (v[m_gnt] && tx_rdy) begin
                m_gap = 0;
                if (l[m_gnt]) m_gnt = -1;
            end else if (!v[m_gnt]) begin
                m_gap++;
                if (m_gap == TO) begin
                    m_gap = 0; m_gnt = -1; m_pulse = 1;
                    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                end
            end
        end
    end

    // per-cycle comparison of every output against the model
    bit chk_en = 0;
    int npulse = 0;
    logic [7:0] tx_log[$];
    logic [NR-1:0] e_goh;
    logic e_busy, e_txv;
    logic [W-1:0] e_txd;
    always @(negedge QClk) if (chk_en) begin
        e_busy = m_gnt >= 0;
        e_goh = e_busy ? (NR'(1) << m_gnt) : '0;
        e_txv = e_busy && !rst && v[m_gnt];
        e_txd = e_busy ? W'(d >> (m_gnt * W)) : '0;
        chk("GrantOH", GrantOH, e_goh);
        chk("Busy", Busy, e_busy);
        chk("TxValid", TxValid, e_txv);
        chk("TxData", TxData, e_txd);
        chk("ReqReady", ReqReady, (e_busy && !rst && tx_rdy) ? e_goh : '0);
        chk("TimeoutPulse", TimeoutPulse, m_pulse);
        chk("TimeoutCnt", TimeoutCnt, m_cnt);
        if (TxValid && tx_rdy) tx_log.push_back(TxData);
        if (TimeoutPulse) npulse++;
    end

    task automatic tick();
        @(posedge QClk); #2;
    endtask
    task automatic push(input int r, input logic [7:0] dat, input logic last, input int gap);
        beat_t b;
        b.d = dat; b.last = last; b.gap = 16'(gap);
        q[r].push_back(b);
    endtask
    function automatic bit all_empty();
        for (int i = 0; i < NR; i++) if (q[i].size() != 0) return 0;
        return 1;
    endfunction
    task automatic drain(input string name, input int limit);
        int n = 0;
        while ((!all_empty() || Busy) && n < limit) begin tick(); n++; end
        chk(name, n < limit, 1);
        tick();
    endtask
    task automatic wait_acc(input string name, input int r, input int base);
        int n = 0;
        while (acc_cnt[r] == base && n < 50) begin tick(); n++; end
        chk(name, n < 50, 1);
    endtask

    initial begin
        int n, base, p0, len, r;
        tick();
        chk_en = 1; rst = 0;
        chk("rst_grant", GrantOH, 0); chk("rst_busy", Busy, 0);
        chk("rst_cnt", TimeoutCnt, 0); chk("rst_pulse", TimeoutPulse, 0);

        tx_rdy = 1;
        push(2, 8'h41, 0, 0); push(2, 8'h42, 0, 0); push(2, 8'h43, 1, 0);
        n = 0;
        while (GrantOH == 0 && n < 10) begin tick(); n++; end
        chk("t1_latency", n, 2);
        chk("t1_grant", GrantOH, 4'b0100); chk("t1_txv", TxValid, 1); chk("t1_b0", TxData, 8'h41);
        tick(); chk("t1_b1", TxData, 8'h42);
        tick(); chk("t1_b2", TxData, 8'h43);
        tick(); chk("t1_idle_grant", GrantOH, 0); chk("t1_idle_busy", Busy, 0);

        rst = 1; tick(); rst = 0;
        tx_log.delete();
        for (int i = 0; i < NR; i++) begin
            push(i, 8'(i * 16), 0, 0);
            push(i, 8'(i * 16 + 1), 1, 0);
        end
        drain("t2_drain", 200);
        chk("t2_count", tx_log.size(), 8);
        for (int i = 0; i < 8; i++) chk("t2_order", tx_log[i], 8'((i / 2) * 16 + i % 2));

        base = acc_cnt[1];
        push(1, 8'h10, 0, 0); push(1, 8'h11, 0, 0); push(1, 8'h12, 1, 0);
        wait_acc("t3_first", 1, base);
        tx_rdy = 0; p0 = npulse;
        repeat (2000) tick();
        chk("t3_busy", Busy, 1); chk("t3_grant", GrantOH, 4'b0010);
        chk("t3_data", TxData, 8'h11); chk("t3_rdy", ReqReady, 0);
        chk("t3_nopulse", npulse - p0, 0);
        tx_rdy = 1;
        drain("t3_drain", 50);
        chk("t3_beats", acc_cnt[1] - base, 3);

        base = acc_cnt[0];
        push(0, 8'hA0, 0, 0); push(0, 8'hA1, 0, 0); push(0, 8'hA2, 0, 0); push(0, 8'hA3, 1, 0);
        wait_acc("t5_first", 0, base);
        chk("t5_mid", TxData, 8'hA1);
        rst = 1; q[0].delete(); tick(); rst = 0;
        chk("t5_grant", GrantOH, 0); chk("t5_busy", Busy, 0); chk("t5_txv", TxValid, 0);
        chk("t5_txd", TxData, 0); chk("t5_rdy", ReqReady, 0); chk("t5_cnt", TimeoutCnt, 0);
        push(0, 8'hB0, 1, 0); push(2, 8'hB2, 1, 0);
        n = 0;
        while (GrantOH == 0 && n < 10) begin tick(); n++; end
        chk("t5_pri", GrantOH, 4'b0001);
        drain("t5_drain", 50);

        base = acc_cnt[1];
        push(1, 8'h55, 0, 0);
        wait_acc("t4_beat", 1, base);
        push(3, 8'h77, 1, 0);
        n = 0;
        while (!TimeoutPulse && n < 40) begin tick(); n++; end
        chk("t4_delay", n, 16); chk("t4_cnt", TimeoutCnt, 1); chk("t4_idle", GrantOH, 0);
        tick(); chk("t4_regrant", GrantOH, 4'b1000);
        drain("t4_drain", 50);

        for (int p = 0; p < 6; p++)
            for (int i = 0; i < NR; i++) begin
                len = 1 + int'($urandom % 4);
                for (int b = 0; b < len; b++) begin
                    r = int'($urandom % 10);
                    push(i, 8'($urandom), b == len - 1,
                         r < 6 ? 0 : r < 9 ? int'($urandom % 4) : 17 + int'($urandom % 8));
                end
            end
        n = 0;
        while ((!all_empty() || Busy) && n < 20000) begin
            tx_rdy = ($urandom % 4) != 0;
            tick(); n++;
        end
        chk("rand_drain", n < 20000, 1);
        tx_rdy = 1;

        rst = 1; tick(); rst = 0;
        p0 = npulse;
        for (int k = 0; k < 300; k++) push(1, 8'(k), 0, k == 0 ? 0 : 20);
        drain("t6_drain", 20000);
        chk("t6_cnt", TimeoutCnt, 255);
        chk("t6_pulses", npulse - p0, 300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
